// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's program-load, redirect and decode-side handshake signals.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          imem_we;
  logic [31:0]   imem_waddr;
  logic [31:0]   imem_wdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_pc;
  logic [31:0]   inst_data;
  logic [CW-1:0] queue_count;

  modport master (
    input  imem_we, imem_waddr, imem_wdata,
    input  redirect_valid, redirect_pc,
    input  inst_ready,
    output inst_valid, inst_pc, inst_data, queue_count
  );

  modport slave (
    output imem_we, imem_waddr, imem_wdata,
    output redirect_valid, redirect_pc,
    output inst_ready,
    input  inst_valid, inst_pc, inst_data, queue_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC sequencer, loadable instruction memory and a
// circular instruction queue with valid/ready backpressure and redirect flush.
module fetch_unit #(
  parameter int          IMEM_DEPTH  = 32,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;

  logic [31:0]   mem    [IMEM_DEPTH];
  logic [31:0]   pc_q   [QUEUE_DEPTH];
  logic [31:0]   data_q [QUEUE_DEPTH];
  logic [31:0]   fetch_pc;
  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [CW-1:0] count;
  logic          not_empty;
  logic          pop;
  logic          push;
  logic [31:0]   fetch_word;
  logic          unused_bits;

  assign unused_bits = ^{bus.imem_waddr[31:AW+2], bus.imem_waddr[1:0], bus.redirect_pc[1:0]};

  // A redirect wins over both ends of the queue, so it masks pop as well as push.
  assign not_empty  = (count != '0);
  assign pop        = not_empty && bus.inst_ready && !bus.redirect_valid;
  assign push       = !bus.redirect_valid && ((count < CW'(QUEUE_DEPTH)) || pop);
  assign fetch_word = mem[fetch_pc[AW+1:2]];

  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_waddr[AW+1:2]] <= bus.imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]   <= fetch_pc;
      data_q[tail] <= fetch_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail     <= tail + QW'(1);
      end
      if (pop) begin
        head <= head + QW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Empty queue presents zeros so stale entries never leak after a flush.
  assign bus.inst_valid  = not_empty;
  assign bus.inst_pc     = not_empty ? pc_q[head]   : 32'h0;
  assign bus.inst_data   = not_empty ? data_q[head] : 32'h0;
  assign bus.queue_count = count;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model.
module tb_fetch_unit;
  localparam int          IMEM_DEPTH  = 32;
  localparam int          QUEUE_DEPTH = 4;
  localparam logic [31:0] RESET_PC    = 32'h0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_unit_if #(.QUEUE_DEPTH(QUEUE_DEPTH)) bus ();

  fetch_unit #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mmem [IMEM_DEPTH];
  logic [31:0] q_pc[$];
  logic [31:0] q_data[$];
  logic [31:0] mpc;
  int total  = 0;
  int passed = 0;
  int fails  = 0;

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % IMEM_DEPTH);
  endfunction

  // Reference behaviour for one clock edge, evaluated from the inputs now applied.
  task automatic model_update();
    logic pop_now;
    if (reset) begin
      q_pc.delete();
      q_data.delete();
      mpc = RESET_PC;
    end else if (bus.redirect_valid) begin
      q_pc.delete();
      q_data.delete();
      mpc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      pop_now = (q_pc.size() > 0) && bus.inst_ready;
      if (pop_now) begin
        void'(q_pc.pop_front());
        void'(q_data.pop_front());
      end
      if (q_pc.size() < QUEUE_DEPTH) begin
        q_pc.push_back(mpc);
        q_data.push_back(mmem[widx(mpc)]);
        mpc = mpc + 32'd4;
      end
    end
    if (bus.imem_we) mmem[widx(bus.imem_waddr)] = bus.imem_wdata;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output(string tag);
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    e_valid = (q_pc.size() > 0);
    e_pc    = e_valid ? q_pc[0]   : 32'h0;
    e_data  = e_valid ? q_data[0] : 32'h0;
    check({tag, ".valid"}, 32'(bus.inst_valid),  32'(e_valid));
    check({tag, ".pc"},    bus.inst_pc,          e_pc);
    check({tag, ".data"},  bus.inst_data,        e_data);
    check({tag, ".count"}, 32'(bus.queue_count), 32'(q_pc.size()));
  endtask

  task automatic apply_stimulus(logic rdy, logic rv, logic [31:0] rpc,
                                logic we, logic [31:0] wa, logic [31:0] wd);
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_we        = we;
    bus.imem_waddr     = wa;
    bus.imem_wdata     = wd;
  endtask

  task automatic step(string tag);
    model_update();
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  task automatic restart();
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step("reset");
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h005303b3;
    prog[1] = 32'h00000013;
    prog[2] = 32'h00100093;
    prog[3] = 32'h00208133;

    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    mpc = RESET_PC;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'(i * 4),
                     (i < 4) ? prog[i] : $urandom);
      step("load");
    end

    $display("[TB] stream with ready held high");
    reset = 1'b0;
    apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step("stream");
      check("stream.pc_abs", bus.inst_pc, 32'(i * 4));
      check("stream.word_abs", bus.inst_data, prog[i]);
    end

    $display("[TB] backpressure fill and drain");
    restart();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step("fill");
    check("fill.count_abs", 32'(bus.queue_count), 32'd4);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("drain.pc_abs", bus.inst_pc, 32'(i * 4));
      step("drain");
    end

    $display("[TB] redirect flush with concurrent pop");
    restart();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step("pre_redir");
    step("pre_redir");
    apply_stimulus(1'b1, 1'b1, 32'h22, 1'b0, 32'h0, 32'h0);
    step("redir");
    check("redir.count_abs", 32'(bus.queue_count), 32'd0);
    bus.redirect_valid = 1'b0;
    step("post_redir");
    check("post_redir.pc_abs", bus.inst_pc, 32'h20);

    $display("[TB] redirect near memory end wraps the word index");
    apply_stimulus(1'b1, 1'b1, 32'h7C, 1'b0, 32'h0, 32'h0);
    step("wrap_redir");
    bus.redirect_valid = 1'b0;
    step("wrap0");
    check("wrap0.word_abs", bus.inst_data, mmem[31]);
    step("wrap1");
    check("wrap1.pc_abs", bus.inst_pc, 32'h80);
    check("wrap1.word_abs", bus.inst_data, mmem[0]);

    $display("[TB] write and fetch of the same word");
    apply_stimulus(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step("wf_redir");
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'hDEADBEEF);
    step("wf_write");
    check("wf_write.old_abs", bus.inst_data, prog[2]);
    apply_stimulus(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    step("wf_redir2");
    bus.redirect_valid = 1'b0;
    step("wf_new");
    check("wf_new.word_abs", bus.inst_data, 32'hDEADBEEF);

    $display("[TB] asynchronous reset mid-stream");
    restart();
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step("pre_areset");
    check("pre_areset.count_abs", 32'(bus.queue_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("areset.valid", 32'(bus.inst_valid), 32'd0);
    check("areset.count", 32'(bus.queue_count), 32'd0);
    q_pc.delete();
    q_data.delete();
    mpc = RESET_PC;
    step("areset_hold");
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    step("areset_restart");
    check("areset_restart.pc_abs", bus.inst_pc, RESET_PC);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 11) == 0),
                     ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255)),
                     1'($urandom_range(0, 4) == 0),
                     $urandom, $urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
